// File: rtl/gradient_weight_y.sv
// Vertical [1 2 1]/4 smoothing of three 32-bit gradient streams using two line buffers per channel.
// Optional GRADIENT_WEIGHT_Y_ZERO_PAD_EN: emit rows 0 and 1 with missing rows treated as zero.
module gradient_weight_y #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic [31:0] Input_1_V_V,
  input  logic        Input_1_V_V_ap_vld,
  output logic        Input_1_V_V_ap_ack,
  input  logic [31:0] Input_2_V_V,
  input  logic        Input_2_V_V_ap_vld,
  output logic        Input_2_V_V_ap_ack,
  input  logic [31:0] Input_3_V_V,
  input  logic        Input_3_V_V_ap_vld,
  output logic        Input_3_V_V_ap_ack,
  output logic [31:0] Output_1_V_V,
  output logic        Output_1_V_V_ap_vld,
  input  logic        Output_1_V_V_ap_ack,
  output logic [31:0] Output_2_V_V,
  output logic        Output_2_V_V_ap_vld,
  input  logic        Output_2_V_V_ap_ack,
  output logic [31:0] Output_3_V_V,
  output logic        Output_3_V_V_ap_vld,
  input  logic        Output_3_V_V_ap_ack
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
  localparam logic [RW-1:0] Row1    = RW'(1);
  localparam logic [RW-1:0] Row2    = RW'(2);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [31:0]   r_out [3];
  logic [2:0]    r_vld;
  logic [31:0]   r_lb1 [3][IMG_W];  // row r-1
  logic [31:0]   r_lb2 [3][IMG_W];  // row r-2

  logic [31:0] w_in [3];
  logic [2:0]  w_in_vld;
  logic [2:0]  w_out_ack;
  logic        w_accept;
  logic        w_emit;
  logic [31:0] w_p1 [3];
  logic [31:0] w_p2 [3];
  logic [33:0] w_sum [3];
  logic [31:0] w_res [3];

  assign w_in[0]   = Input_1_V_V;
  assign w_in[1]   = Input_2_V_V;
  assign w_in[2]   = Input_3_V_V;
  assign w_in_vld  = {Input_3_V_V_ap_vld, Input_2_V_V_ap_vld, Input_1_V_V_ap_vld};
  assign w_out_ack = {Output_3_V_V_ap_ack, Output_2_V_V_ap_ack, Output_1_V_V_ap_ack};

  // Slot is usable when every channel is either empty or being acked this cycle.
  assign w_accept = ap_rst_n & (&w_in_vld) & (&(~r_vld | w_out_ack));

`ifdef GRADIENT_WEIGHT_Y_ZERO_PAD_EN
  assign w_emit = 1'b1;
`else
  assign w_emit = (r_row >= Row2);
`endif

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_p1[k] = r_lb1[k][r_col];
      w_p2[k] = r_lb2[k][r_col];
`ifdef GRADIENT_WEIGHT_Y_ZERO_PAD_EN
      if (r_row < Row1) w_p1[k] = '0;
      if (r_row < Row2) w_p2[k] = '0;
`endif
      w_sum[k] = {{2{w_p2[k][31]}}, w_p2[k]} + {w_p1[k][31], w_p1[k], 1'b0}
               + {{2{w_in[k][31]}}, w_in[k]};
      w_res[k] = w_sum[k][33:2];
    end
  end

  // Line buffers are intentionally not reset; the row gating keeps stale words off the output.
  always_ff @(posedge ap_clk) begin
    if (w_accept) begin
      for (int k = 0; k < 3; k++) begin
        r_lb2[k][r_col] <= r_lb1[k][r_col];
        r_lb1[k][r_col] <= w_in[k];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_vld <= '0;
      for (int k = 0; k < 3; k++) r_out[k] <= '0;
    end else begin
      if (w_accept) begin
        if (r_col == ColLast) begin
          r_col <= '0;
          r_row <= (r_row == RowLast) ? '0 : r_row + Row1;
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_accept && w_emit) begin
        r_vld <= 3'b111;
        for (int k = 0; k < 3; k++) r_out[k] <= w_res[k];
      end else begin
        r_vld <= r_vld & ~w_out_ack;
      end
    end
  end

  assign Input_1_V_V_ap_ack  = w_accept;
  assign Input_2_V_V_ap_ack  = w_accept;
  assign Input_3_V_V_ap_ack  = w_accept;
  assign Output_1_V_V        = r_out[0];
  assign Output_2_V_V        = r_out[1];
  assign Output_3_V_V        = r_out[2];
  assign Output_1_V_V_ap_vld = r_vld[0];
  assign Output_2_V_V_ap_vld = r_vld[1];
  assign Output_3_V_V_ap_vld = r_vld[2];

endmodule
